// File: rtl/decode_queue.sv
// RV32I decode queue: DEPTH-entry instruction FIFO feeding a registered decode stage.
// Optional macro DECODE_MEXT_EN accepts the M-extension R-type encodings (funct7=0000001).
module decode_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [31:0]               in_instr_i,
   input  logic [ADDR_W-1:0]         in_pc_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [ADDR_W-1:0]         out_pc_o,
   output logic [31:0]               out_imm_o,
   output logic                      out_imm_en_o,
   output logic [6:0]                out_op_o,
   output logic [2:0]                out_funct3_o,
   output logic [7:0]                out_funct7_o,
   output logic [4:0]                out_rd_addr_o,
   output logic [4:0]                out_rs1_addr_o,
   output logic [4:0]                out_rs2_addr_o,
   output logic                      out_rd_en_o,
   output logic                      out_rs1_en_o,
   output logic                      out_rs2_en_o,
   output logic [4:0]                out_mem_op_o,
   output logic                      out_jump_en_o,
   output logic                      out_illegal_o,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
`ifdef DECODE_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif

   logic [31:0]       instr_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem    [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              push, pop;

   assign count_o    = count;
   assign in_ready_o = (count != CW'(DEPTH));
   assign push       = in_valid_i & in_ready_o;
   assign pop        = (count != '0) & (!out_valid_o | out_ready_i);

   always_ff @(posedge clk) begin
      if (push && !flush_i) begin
         instr_mem[wr_ptr] <= in_instr_i;
         pc_mem[wr_ptr]    <= in_pc_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Combinational decode of the head entry
   logic [31:0] ins;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        is_r, is_imm, is_load, is_jalr, is_s, is_b, is_u, is_j, is_i;
   logic        illegal;
   logic [31:0] imm;
   logic        imm_en, rd_en, rs1_en, rs2_en, jump_en;
   logic [4:0]  mem_op;

   assign ins = instr_mem[rd_ptr];
   assign op  = ins[6:0];
   assign f3  = ins[14:12];
   assign f7  = ins[31:25];

   always_comb begin
      is_r    = (op == 7'b0110011);
      is_imm  = (op == 7'b0010011);
      is_load = (op == 7'b0000011);
      is_jalr = (op == 7'b1100111);
      is_s    = (op == 7'b0100011);
      is_b    = (op == 7'b1100011);
      is_u    = (op == 7'b0110111) | (op == 7'b0010111);
      is_j    = (op == 7'b1101111);
      is_i    = is_imm | is_load | is_jalr;

      illegal = (ins[1:0] != 2'b11) | !(is_r | is_i | is_s | is_b | is_u | is_j);
      if (is_load && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) illegal = 1'b1;
      if (is_s && f3 > 3'b010) illegal = 1'b1;
      if (is_b && (f3 == 3'b010 || f3 == 3'b011)) illegal = 1'b1;
      if (is_jalr && f3 != 3'b000) illegal = 1'b1;
      if (is_r) begin
         if (f7 == 7'b0100000) begin
            if (f3 != 3'b000 && f3 != 3'b101) illegal = 1'b1;
         end else if (f7 == 7'b0000001) begin
            if (!MEXT) illegal = 1'b1;
         end else if (f7 != 7'b0000000) begin
            illegal = 1'b1;
         end
      end
      if (is_imm && f3 == 3'b001 && f7 != 7'b0000000) illegal = 1'b1;
      if (is_imm && f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) illegal = 1'b1;

      imm = '0;
      if (is_i)      imm = {{20{ins[31]}}, ins[31:20]};
      else if (is_s) imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      else if (is_b) imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      else if (is_u) imm = {ins[31:12], 12'b0};
      else if (is_j) imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

      imm_en  = is_i | is_s | is_b | is_u | is_j;
      rd_en   = !is_s & !is_b & (ins[11:7] != 5'd0);
      rs1_en  = !is_u & !is_j & (ins[19:15] != 5'd0);
      rs2_en  = is_r | is_s | is_b;
      jump_en = is_j | is_jalr | is_b;
      mem_op  = {is_s, is_load, (is_s | is_load) ? f3 : 3'b111};

      // Illegal instructions must not trigger any side effect downstream
      if (illegal) begin
         imm     = '0;
         imm_en  = 1'b0;
         rd_en   = 1'b0;
         rs1_en  = 1'b0;
         rs2_en  = 1'b0;
         jump_en = 1'b0;
         mem_op  = 5'b00111;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_o    <= 1'b0;
         out_pc_o       <= '0;
         out_imm_o      <= '0;
         out_imm_en_o   <= 1'b0;
         out_op_o       <= '0;
         out_funct3_o   <= '0;
         out_funct7_o   <= '0;
         out_rd_addr_o  <= '0;
         out_rs1_addr_o <= '0;
         out_rs2_addr_o <= '0;
         out_rd_en_o    <= 1'b0;
         out_rs1_en_o   <= 1'b0;
         out_rs2_en_o   <= 1'b0;
         out_mem_op_o   <= 5'b00111;
         out_jump_en_o  <= 1'b0;
         out_illegal_o  <= 1'b0;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
      end else if (pop) begin
         out_valid_o    <= 1'b1;
         out_pc_o       <= pc_mem[rd_ptr];
         out_imm_o      <= imm;
         out_imm_en_o   <= imm_en;
         out_op_o       <= op;
         out_funct3_o   <= f3;
         out_funct7_o   <= {1'b0, f7};
         out_rd_addr_o  <= ins[11:7];
         out_rs1_addr_o <= ins[19:15];
         out_rs2_addr_o <= ins[24:20];
         out_rd_en_o    <= rd_en;
         out_rs1_en_o   <= rs1_en;
         out_rs2_en_o   <= rs2_en;
         out_mem_op_o   <= mem_op;
         out_jump_en_o  <= jump_en;
         out_illegal_o  <= illegal;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule
